// File: rtl/frame_tx.sv
// frame_tx -- Ethernet-style frame transmitter.
//
// On an accepted start request the header fields are latched and one
// contiguous tx_en burst is produced: 7 x 0x55, 0xD5, dmac, smac, ether_type
// (all MSB byte first), L payload bytes pulled from an upstream byte source,
// zero padding up to MIN_PLOAD payload bytes and, optionally, a 4-byte FCS.
// After the burst (or an underrun abort) IFG idle cycles follow with busy
// still high.
//
// Optional feature macro: FRAME_TX_FCS_EN
//   defined   -> IEEE 802.3 CRC-32 FCS is generated and appended.
//   undefined -> no CRC logic, the frame ends after the last pad/payload byte.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             frame request, sampled only while busy=0
//   dmac, smac        destination / source MAC, latched on start
//   ether_type        type/length field, latched on start
//   pload_len         payload byte count L, latched on start
//   pl_data/pl_valid  upstream payload byte and its valid
//   pl_ready          payload byte requested (transfer = pl_valid && pl_ready)
//   txd, tx_en        transmit byte and its valid (txd=0 while tx_en=0)
//   busy              frame in progress or in inter-frame gap
//   done              one-cycle pulse after a normally completed frame
//   err               one-cycle pulse: start rejected (L>MAX_PLOAD) or underrun
module frame_tx #(
  parameter int MIN_PLOAD = 46,
  parameter int MAX_PLOAD = 1500,
  parameter int IFG       = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [47:0] dmac,
  input  logic [47:0] smac,
  input  logic [15:0] ether_type,
  input  logic [10:0] pload_len,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [10:0] MIN_L    = 11'(MIN_PLOAD);
  localparam logic [10:0] MAX_L    = 11'(MAX_PLOAD);
  localparam logic [10:0] IFG_LAST = 11'(IFG - 1);
  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;

  typedef enum logic [2:0] {IDLE, PRE, SFD, HDR, PLOAD, PAD, FCS, GAP} state_t;

  // state_reg/cnt_reg describe the byte currently on txd; the next-state
  // logic decides what goes on the wire in the following cycle, which keeps
  // every output a plain register.
  state_t        state_reg, state_next;
  logic [10:0]   cnt_reg, cnt_next;
  logic [10:0]   len_reg, len_next;
  logic [111:0]  hdr_reg, hdr_next;   // {dmac, smac, ether_type}, shifted out MSB byte first
  logic [7:0]    txd_reg, txd_next;
  logic          tx_en_reg, tx_en_next;
  logic          pl_ready_reg, pl_ready_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic [10:0]   pad_len;
  logic          payload_take;        // current cycle has pl_ready high
  logic          payload_end;         // current byte is the last header/payload byte
  logic          tail_start;          // current byte is the last pad/payload byte

`ifdef FRAME_TX_FCS_EN
  logic [31:0]   crc_reg, crc_next;
  logic          crc_init, crc_shift;

  // Reflected CRC-32 over one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction
`endif

  assign pad_len = (len_reg < MIN_L) ? (MIN_L - len_reg) : 11'd0;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    len_next      = len_reg;
    hdr_next      = hdr_reg;
    txd_next      = 8'h00;
    tx_en_next    = 1'b0;
    pl_ready_next = 1'b0;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    payload_take  = 1'b0;
    payload_end   = 1'b0;
    tail_start    = 1'b0;
`ifdef FRAME_TX_FCS_EN
    crc_init      = 1'b0;
    crc_shift     = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (start) begin
          if (pload_len > MAX_L) begin
            err_next = 1'b1;
          end else begin
            len_next   = pload_len;
            hdr_next   = {dmac, smac, ether_type};
            busy_next  = 1'b1;
            state_next = PRE;
            cnt_next   = 11'd0;
            txd_next   = PRE_BYTE;
            tx_en_next = 1'b1;
`ifdef FRAME_TX_FCS_EN
            crc_init   = 1'b1;
`endif
          end
        end
      end

      PRE: begin
        tx_en_next = 1'b1;
        if (cnt_reg == 11'd6) begin
          state_next = SFD;
          txd_next   = SFD_BYTE;
        end else begin
          cnt_next = cnt_reg + 11'd1;
          txd_next = PRE_BYTE;
        end
      end

      SFD: begin
        state_next = HDR;
        cnt_next   = 11'd0;
        tx_en_next = 1'b1;
        txd_next   = hdr_reg[111:104];
        hdr_next   = {hdr_reg[103:0], 8'h00};
      end

      HDR: begin
        if (cnt_reg != 11'd13) begin
          tx_en_next    = 1'b1;
          cnt_next      = cnt_reg + 11'd1;
          txd_next      = hdr_reg[111:104];
          hdr_next      = {hdr_reg[103:0], 8'h00};
          // Payload fetch starts while ether_type[7:0] is on the wire.
          pl_ready_next = (cnt_reg == 11'd12) && (len_reg != 11'd0);
        end else if (len_reg == 11'd0) begin
          payload_end = 1'b1;
        end else begin
          payload_take = 1'b1;
        end
      end

      PLOAD: begin
        if (cnt_reg == len_reg - 11'd1) begin
          payload_end = 1'b1;
        end else begin
          payload_take = 1'b1;
        end
      end

      PAD: begin
        if (cnt_reg == pad_len - 11'd1) begin
          tail_start = 1'b1;
        end else begin
          tx_en_next = 1'b1;
          cnt_next   = cnt_reg + 11'd1;
        end
      end

`ifdef FRAME_TX_FCS_EN
      FCS: begin
        if (cnt_reg == 11'd3) begin
          state_next = GAP;
          cnt_next   = 11'd0;
          done_next  = 1'b1;
        end else begin
          tx_en_next = 1'b1;
          cnt_next   = cnt_reg + 11'd1;
          txd_next   = ~crc_reg[7:0];
          crc_shift  = 1'b1;
        end
      end
`endif

      GAP: begin
        if (cnt_reg == IFG_LAST) begin
          state_next = IDLE;
          cnt_next   = 11'd0;
          busy_next  = 1'b0;
        end else begin
          cnt_next = cnt_reg + 11'd1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 11'd0;
        busy_next  = 1'b0;
      end
    endcase

    // A requested byte that is not there aborts the frame straight into GAP.
    if (payload_take) begin
      if (pl_valid) begin
        state_next    = PLOAD;
        cnt_next      = (state_reg == HDR) ? 11'd0 : cnt_reg + 11'd1;
        tx_en_next    = 1'b1;
        txd_next      = pl_data;
        pl_ready_next = (cnt_next + 11'd1) < len_reg;
      end else begin
        state_next = GAP;
        cnt_next   = 11'd0;
        err_next   = 1'b1;
      end
    end

    if (payload_end) begin
      if (pad_len != 11'd0) begin
        state_next = PAD;
        cnt_next   = 11'd0;
        tx_en_next = 1'b1;
      end else begin
        tail_start = 1'b1;
      end
    end

    if (tail_start) begin
`ifdef FRAME_TX_FCS_EN
      state_next = FCS;
      cnt_next   = 11'd0;
      tx_en_next = 1'b1;
      txd_next   = ~crc_reg[7:0];
      crc_shift  = 1'b1;
`else
      state_next = GAP;
      cnt_next   = 11'd0;
      done_next  = 1'b1;
`endif
    end
  end

`ifdef FRAME_TX_FCS_EN
  // crc_reg always covers every dmac..pad byte already placed on txd, so it
  // is complete in the cycle the last data byte is on the wire; the FCS is
  // then shifted out low byte first.
  always_comb begin
    crc_next = crc_reg;
    if (crc_init) begin
      crc_next = 32'hFFFFFFFF;
    end else if (crc_shift) begin
      crc_next = {8'h00, crc_reg[31:8]};
    end else if (tx_en_next && (state_next == HDR || state_next == PLOAD || state_next == PAD)) begin
      crc_next = crc_byte(crc_reg, txd_next);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_reg <= 32'hFFFFFFFF;
    end else begin
      crc_reg <= crc_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 11'd0;
      len_reg      <= 11'd0;
      hdr_reg      <= '0;
      txd_reg      <= 8'h00;
      tx_en_reg    <= 1'b0;
      pl_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      len_reg      <= len_next;
      hdr_reg      <= hdr_next;
      txd_reg      <= txd_next;
      tx_en_reg    <= tx_en_next;
      pl_ready_reg <= pl_ready_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign txd      = txd_reg;
  assign tx_en    = tx_en_reg;
  assign pl_ready = pl_ready_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign err      = err_reg;

endmodule
